serial_bit_source: RTL and testbench

Parallel-to-serial stage that feeds the single-bit input A of the team's run-of-ones / count-of-ones detector FSMs. It accepts a WIDTH-bit word over a valid/ready handshake and emits it on bit_out, one bit per clk. It then inserts a programmable run of forced-zero gap cycles, so that runs of 1s never span two frames at the downstream detector. bit_out is 0 whenever no data bit is being driven.

---
 rtl/serial_bit_source.sv | 108 ++++++++++
 tb/tb_serial_bit_source.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end for the single-bit detector FSMs: one word per
// frame, then GAP_CYCLES forced-zero cycles. Optional parity bit: SERIAL_PARITY_EN.
module serial_bit_source #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef SERIAL_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic [GW-1:0]        r_gap;
    logic                 r_bit_valid;
    logic                 r_frame_done;
    logic [FRAME_LEN-1:0] w_load;
    logic [FRAME_LEN-1:0] w_shifted;

    // Parity sits at the tail of the frame, so it is placed beyond the last data bit
    // in whichever direction the register drains.
    always_comb begin
`ifdef SERIAL_PARITY_EN
        w_load = LSB_FIRST ? {^in_data, in_data} : {in_data, ^in_data};
`else
        w_load = in_data;
`endif
        w_shifted = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift      <= w_load;
                        r_cnt        <= CNT_LOAD;
                        r_bit_valid  <= 1'b1;
                        r_frame_done <= 1'b0;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_shift      <= '0;
                        r_bit_valid  <= 1'b0;
                        r_frame_done <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_shift      <= w_shifted;
                        r_cnt        <= r_cnt - 1'b1;
                        r_frame_done <= (r_cnt == CW'(1));
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) r_state <= S_IDLE;
                    else             r_gap   <= r_gap - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The head bit of the register is the serial output; the register is all-zero
    // outside SHIFT, which keeps bit_out low in IDLE and GAP.
    assign bit_out    = LSB_FIRST ? r_shift[0] : r_shift[FRAME_LEN-1];
    assign bit_valid  = r_bit_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);
    assign in_ready   = (r_state == S_IDLE) && !rst;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: an MSB-first/gap=1 instance and an LSB-first/gap=0
// instance, both checked every cycle against a frame-position reference model.
module tb_serial_bit_source;

    localparam int W = 8;
`ifdef SERIAL_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int GAP0 = 1;
    localparam int GAP1 = 0;

    typedef struct packed {
        logic b;
        logic v;
        logic d;
        logic r;
        logic y;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din [2];
    logic         vin [2];
    logic         rdy [2];
    logic         bo  [2];
    logic         bv  [2];
    logic         by  [2];
    logic         fd  [2];

    // Model state: cycles since acceptance (-1 when idle) and the captured word.
    int           pos  [2];
    logic [W-1:0] word [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(GAP0)) dut0 (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]),
        .in_ready(rdy[0]), .bit_out(bo[0]), .bit_valid(bv[0]),
        .busy(by[0]), .frame_done(fd[0])
    );

    serial_bit_source #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(GAP1)) dut1 (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]),
        .in_ready(rdy[1]), .bit_out(bo[1]), .bit_valid(bv[1]),
        .busy(by[1]), .frame_done(fd[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP0 : GAP1;
    endfunction

    // Frame bit p: data bits in shift order, then (optionally) even parity of the word.
    function automatic exp_t exp_at(input logic [W-1:0] w, input bit lsb, input int p,
                                    input logic rst_now);
        exp_t e;
        e = '0;
        if (p < 0) begin
            e.r = !rst_now;
        end else begin
            e.y = 1'b1;
            if (p < FL) begin
                e.v = 1'b1;
                e.d = (p == FL - 1);
                if (p < W) e.b = lsb ? w[p] : w[W-1-p];
                else       e.b = ^w;
            end
        end
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e = exp_at(word[d], (d == 1), pos[d], rst);
            check($sformatf("d%0d bit_out", d),    32'(bo[d]),  32'(e.b));
            check($sformatf("d%0d bit_valid", d),  32'(bv[d]),  32'(e.v));
            check($sformatf("d%0d frame_done", d), 32'(fd[d]),  32'(e.d));
            check($sformatf("d%0d in_ready", d),   32'(rdy[d]), 32'(e.r));
            check($sformatf("d%0d busy", d),       32'(by[d]),  32'(e.y));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pos[d] = -1;
            end else if (pos[d] < 0) begin
                if (vin[d]) begin
                    pos[d]  = 0;
                    word[d] = din[d];
                end
            end else begin
                pos[d]++;
                if (pos[d] >= FL + gap_of(d)) pos[d] = -1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int d, input logic [W-1:0] w);
        bit ok;
        ok     = 1'b0;
        din[d] = w;
        vin[d] = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            cycle();
            if (pos[d] == 0) ok = 1'b1;
        end
        vin[d] = 1'b0;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        pos = '{-1, -1};
        compare_all();
    endtask

    initial begin
        pos    = '{-1, -1};
        word   = '{'0, '0};
        din    = '{'0, '0};
        vin    = '{1'b0, 1'b0};
        rst    = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(20);

        send(0, 8'hA5);
        idle(12);

        send(0, 8'hC0);
        send(0, 8'h03);
        idle(12);

        send(1, 8'h01);
        din[1] = 8'hFF;
        vin[1] = 1'b1;
        idle(4);
        vin[1] = 1'b0;
        idle(10);

        send(0, 8'hFF);
        idle(3);
        async_reset();
        din[0] = 8'h55;
        vin[0] = 1'b1;
        idle(2);
        vin[0] = 1'b0;
        rst    = 1'b0;
        cycle();
        send(0, 8'h80);
        idle(12);

        send(0, 8'h07);
        idle(12);
        send(0, 8'h03);
        idle(12);

        for (int i = 0; i < 2000; i++) begin
            for (int d = 0; d < 2; d++) begin
                vin[d] = 1'($urandom_range(0, 1));
                din[d] = W'($urandom);
            end
            cycle();
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
                cycle();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
